// File: rtl/fifo_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pack_pkg
// Purpose  : Shared sizes, chunk-size type and FSM state type for the byte
//            packer that feeds the byte-wide width-converting FIFO.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pack_pkg;

    localparam int IN_BYTES  = 4;   // bytes in one producer lane
    localparam int OUT_BYTES = 8;   // bytes in one FIFO word
    localparam int ACC_BYTES = 12;  // accumulator depth

    // Chunk length code: length = code + 1 bytes
    typedef logic [1:0] chunk_size_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } pack_state_t;

endpackage : fifo_pack_pkg
`default_nettype wire

// File: rtl/fifo_pack_align.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pack_align
// Purpose  : Combinational lane shifter. Places a 1..4 byte chunk at byte
//            offset 0..11 of the 12-byte accumulator image and returns the
//            per-byte write mask plus the shifted data.
// Ports    : i_data     chunk bytes, i_data[7:0] is the first byte
//            i_size     chunk length code (length = code + 1)
//            i_offset   destination byte offset in the accumulator
//            o_mask     one bit per accumulator byte that gets written
//            o_data     chunk bytes at their accumulator positions
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pack_align
    import fifo_pack_pkg::*;
(
    input  logic [IN_BYTES*8-1:0]  i_data,
    input  chunk_size_t            i_size,
    input  logic [3:0]             i_offset,
    output logic [ACC_BYTES-1:0]   o_mask,
    output logic [ACC_BYTES*8-1:0] o_data
);

    // Each destination byte works out which chunk lane would land on it, so
    // every output bit has exactly one driver.
    for (genvar j = 0; j < ACC_BYTES; j++) begin : g_byte
        logic [3:0] w_lane;
        assign w_lane = 4'(j) - i_offset;
        assign o_mask[j] = (4'(j) >= i_offset) && (w_lane <= {2'b00, i_size});
        assign o_data[j*8 +: 8] = i_data[{w_lane[1:0], 3'b000} +: 8];
    end

endmodule : fifo_pack_align
`default_nettype wire

// File: rtl/fifo_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_byte_packer
// Purpose  : Write-side front end of the byte-wide width-converting FIFO.
//            Packs 1..4 byte chunks little-endian into 64-bit words, never
//            writes while the FIFO is full, and supports a padded flush.
// Ports    : clock, reset    single clock, synchronous active-high reset
//            in_valid/in_data/in_size/in_ready   producer chunk handshake
//            flush / flush_done                  flush request / done pulse
//            fifo_full / fifo_write / fifo_data_in  FIFO write interface
// Config   : PACKER_SVA_EN - when defined, embedded concurrent assertions
// Revision : 1.0 - initial release
// ============================================================================
module fifo_byte_packer
    import fifo_pack_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [IN_BYTES*8-1:0]  in_data,
    input  chunk_size_t            in_size,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   flush_done,
    input  logic                   fifo_full,
    output logic                   fifo_write,
    output logic [OUT_BYTES*8-1:0] fifo_data_in
);

    localparam logic [3:0] c_word_bytes = 4'(OUT_BYTES);

    pack_state_t            r_state;
    logic [3:0]             r_cnt;
    logic [ACC_BYTES*8-1:0] r_acc;

    logic                   w_emit;
    logic                   w_accept;
    logic [ACC_BYTES*8-1:0] w_base_acc;
    logic [3:0]             w_base_cnt;
    logic [ACC_BYTES-1:0]   w_wr_mask;
    logic [ACC_BYTES*8-1:0] w_wr_data;
    logic [ACC_BYTES*8-1:0] w_bit_mask;
    logic [ACC_BYTES*8-1:0] w_acc_next;
    logic [3:0]             w_cnt_next;

    assign w_emit   = !fifo_full &&
                      ((r_cnt >= c_word_bytes) || ((r_state == S_FLUSH) && (r_cnt != 4'd0)));
    assign in_ready = (r_state == S_RUN) && ((r_cnt < c_word_bytes) || !fifo_full);
    assign w_accept = in_valid && in_ready;

    assign fifo_write = w_emit;
    assign flush_done = (r_state == S_DONE);

    // Image of the accumulator after this cycle's emit (if any); the new chunk
    // is placed on top of it, so emit and accept can share a cycle.
    assign w_base_acc = w_emit ? {{OUT_BYTES*8{1'b0}}, r_acc[ACC_BYTES*8-1:OUT_BYTES*8]} : r_acc;
    assign w_base_cnt = !w_emit                 ? r_cnt :
                        (r_cnt >= c_word_bytes) ? r_cnt - c_word_bytes : 4'd0;

    fifo_pack_align u_align (
        .i_data   (in_data),
        .i_size   (in_size),
        .i_offset (w_base_cnt),
        .o_mask   (w_wr_mask),
        .o_data   (w_wr_data)
    );

    for (genvar j = 0; j < ACC_BYTES; j++) begin : g_mask
        assign w_bit_mask[j*8 +: 8] = {8{w_wr_mask[j] & w_accept}};
    end

    assign w_acc_next = (w_base_acc & ~w_bit_mask) | (w_wr_data & w_bit_mask);
    assign w_cnt_next = w_base_cnt + (w_accept ? ({2'b00, in_size} + 4'd1) : 4'd0);

    // Output word: bytes past the fill level are padded on a partial word.
    // An empty packer presents all zeros regardless of the pad value.
    for (genvar k = 0; k < OUT_BYTES; k++) begin : g_out
        assign fifo_data_in[k*8 +: 8] =
            (r_cnt == 4'd0)                          ? 8'h00 :
            ((r_cnt >= c_word_bytes) || (4'(k) < r_cnt)) ? r_acc[k*8 +: 8] : PAD_BYTE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
            r_acc   <= '0;
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            case (r_state)
                S_RUN:   if (flush) r_state <= S_FLUSH;
                // Leave only once a cycle has been spent with nothing held
                S_FLUSH: if (r_cnt == 4'd0) r_state <= S_DONE;
                S_DONE:  r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef PACKER_SVA_EN
    a_no_write_full: assert property (@(posedge clock) disable iff (reset)
        fifo_write |-> !fifo_full)
        else $display("%0t a_no_write_full", $time);
    a_cnt_range: assert property (@(posedge clock) disable iff (reset)
        r_cnt <= 4'd11)
        else $display("%0t a_cnt_range", $time);
    a_done_pulse: assert property (@(posedge clock) disable iff (reset)
        flush_done |=> !flush_done)
        else $display("%0t a_done_pulse", $time);
    a_full_stall: assert property (@(posedge clock) disable iff (reset)
        ((r_cnt >= c_word_bytes) && fifo_full) |-> !in_ready)
        else $display("%0t a_full_stall", $time);
`else
    // No embedded checking in this build.
`endif

endmodule : fifo_byte_packer
`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_byte_packer
// Purpose  : Self-checking bench for fifo_byte_packer. Two instances share
//            the stimulus, one with the default pad and one padding with FF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_byte_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        flush;
    logic        fifo_full;

    logic        in_ready0,   in_ready1;
    logic        flush_done0, flush_done1;
    logic        fifo_write0, fifo_write1;
    logic [63:0] data0,       data1;

    int checks = 0;
    int errors = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] exp0, exp1;

    always #5 clock = ~clock;

    fifo_byte_packer u_dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_size(in_size), .in_ready(in_ready0), .flush(flush),
        .flush_done(flush_done0), .fifo_full(fifo_full),
        .fifo_write(fifo_write0), .fifo_data_in(data0)
    );

    fifo_byte_packer #(.PAD_BYTE(8'hFF)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_size(in_size), .in_ready(in_ready1), .flush(flush),
        .flush_done(flush_done1), .fifo_full(fifo_full),
        .fifo_write(fifo_write1), .fifo_data_in(data1)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] e0, input logic [63:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the chunk is taken.
    task automatic send(input logic [31:0] d, input logic [1:0] s);
        bit taken = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_size  = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (in_ready0) begin
                taken = 1;
                break;
            end
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 20 cycles");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_size  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard monitors: every write must match the oldest expected word.
    always @(negedge clock) begin
        if (!reset && fifo_write0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL word0: got write %h, expected no write", data0);
            end else begin
                exp0 = q0.pop_front();
                if (data0 !== exp0) begin
                    errors++;
                    $display("FAIL word0: got %h, expected %h", data0, exp0);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && fifo_write1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL word1: got write %h, expected no write", data1);
            end else begin
                exp1 = q1.pop_front();
                if (data1 !== exp1) begin
                    errors++;
                    $display("FAIL word1: got %h, expected %h", data1, exp1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset with random inputs
        reset = 1'b1;
        repeat (3) begin
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            in_size   = 2'($urandom);
            flush     = 1'($urandom);
            fifo_full = 1'($urandom);
            @(posedge clock);
            @(negedge clock);
            check("rst_write",      64'(fifo_write0), 64'd0);
            check("rst_data",       data0,            64'd0);
            check("rst_flush_done", 64'(flush_done0), 64'd0);
            check("rst_in_ready",   64'(in_ready0),   64'd1);
        end
        in_valid = 0; in_data = '0; in_size = '0; flush = 0; fifo_full = 0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 2. two full chunks make one word
        push(64'h0706050403020100, 64'h0706050403020100);
        send(32'h03020100, 2'd3);
        send(32'h07060504, 2'd3);
        idle(2);

        // 3. mixed sizes, upper chunk bytes ignored, 3 bytes left over
        push(64'h0504030201CCBBAA, 64'h0504030201CCBBAA);
        send(32'hDEADBEAA, 2'd0);
        send(32'hDEADCCBB, 2'd1);
        send(32'h04030201, 2'd3);
        send(32'h08070605, 2'd3);
        // accepted in the same cycle as the emit of the word above
        send(32'h0C0B0A09, 2'd3);

        // 4. full word held while the FIFO is full
        push(64'h0D0C0B0A09080706, 64'h0D0C0B0A09080706);
        fifo_full = 1'b1;
        send(32'h1111110D, 2'd0);
        repeat (5) begin
            @(negedge clock);
            check("full_write",    64'(fifo_write0), 64'd0);
            check("full_in_ready", 64'(in_ready0),   64'd0);
            check("full_data",     data0,            64'h0D0C0B0A09080706);
        end
        @(posedge clock);
        #1;
        fifo_full = 1'b0;
        idle(3);

        // 5. flush of a 3-byte partial word, both pad values
        send(32'h99332211, 2'd2);
        push(64'h0000000000332211, 64'hFFFFFFFFFF332211);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k == 0) check("flush_in_ready", 64'(in_ready0), 64'd0);
            check("flush_done0", 64'(flush_done0), 64'(k == 2));
            check("flush_done1", 64'(flush_done1), 64'(k == 2));
        end
        @(posedge clock);
        #1;

        // flush with nothing held: done two cycles after the request
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("empty_flush_done", 64'(flush_done0), 64'(k == 1));
        end
        @(posedge clock);
        #1;

        // 6. reset in the middle of a flush with 5 bytes held
        send(32'h04030201, 2'd3);
        send(32'h00000005, 2'd0);
        fifo_full = 1'b1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("midflush_write", 64'(fifo_write0), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        fifo_full = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_write",      64'(fifo_write0), 64'd0);
            check("post_rst_flush_done", 64'(flush_done0), 64'd0);
            check("post_rst_in_ready",   64'(in_ready0),   64'd1);
            check("post_rst_data",       data0,            64'd0);
        end
        @(posedge clock);
        #1;
        // held bytes were discarded: the next word holds only new bytes
        push(64'h8877665544332211, 64'h8877665544332211);
        send(32'h44332211, 2'd3);
        send(32'h88776655, 2'd3);
        idle(4);

        check("queue0_empty", 64'(q0.size()), 64'd0);
        check("queue1_empty", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_byte_packer
`default_nettype wire
